// File: rtl/nn_eval_pkg.sv
// Shared state encoding and default sizing for the NN evaluation sequencer.
`timescale 1ns/1ps
package nn_eval_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefSampleLen  = 784;
  localparam int unsigned DefNumClasses = 10;
  localparam int unsigned DefNumSamples = 1000;
  localparam int unsigned DefTimeout    = 4096;
  localparam int unsigned DefClassWidth = $clog2(DefNumClasses);
  localparam int unsigned DefAddrWidth  = $clog2(DefNumSamples * (DefSampleLen + 1));

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLabel,
    StWait,
    StScore,
    StDone
  } state_e;

endpackage

// File: rtl/nn_eval_sequencer_if.sv
// Sample-memory read port and network stream/result port of the sequencer.
`timescale 1ns/1ps
interface nn_eval_sequencer_if
  import nn_eval_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned CLASS_WIDTH = DefClassWidth,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth
);
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_rd_data;
  logic                   net_valid;
  logic [DATA_WIDTH-1:0]  net_data;
  logic                   net_out_valid;
  logic [CLASS_WIDTH-1:0] net_out_data;

  modport master (
    output mem_rd_en, mem_addr, net_valid, net_data,
    input  mem_rd_data, net_out_valid, net_out_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, net_valid, net_data,
    output mem_rd_data, net_out_valid, net_out_data
  );
endinterface

// File: rtl/nn_eval_class_counters.sv
// Per-class saturating hit/total counters with a combinational class_sel readout.
`timescale 1ns/1ps
module nn_eval_class_counters #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CLASS_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 10,
  parameter int unsigned SAT_VALUE   = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   update,
  input  logic [CLASS_WIDTH-1:0] label,
  input  logic                   hit,
  input  logic [CLASS_WIDTH-1:0] class_sel,
  output logic [CNT_WIDTH-1:0]   class_hits,
  output logic [CNT_WIDTH-1:0]   class_total
);
  localparam logic [CNT_WIDTH-1:0] Sat = CNT_WIDTH'(SAT_VALUE);

  logic [CNT_WIDTH-1:0] hits_q  [NUM_CLASSES];
  logic [CNT_WIDTH-1:0] total_q [NUM_CLASSES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        hits_q[i]  <= '0;
        total_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) begin
        hits_q[i]  <= '0;
        total_q[i] <= '0;
      end
    end else if (update && (label < CLASS_WIDTH'(NUM_CLASSES))) begin
      if (total_q[label] != Sat) total_q[label] <= total_q[label] + 1'b1;
      if (hit && (hits_q[label] != Sat)) hits_q[label] <= hits_q[label] + 1'b1;
    end
  end

  // Encodings beyond the last class read back as zero rather than aliasing.
  always_comb begin
    class_hits  = '0;
    class_total = '0;
    if (class_sel < CLASS_WIDTH'(NUM_CLASSES)) begin
      class_hits  = hits_q[class_sel];
      class_total = total_q[class_sel];
    end
  end
endmodule

// File: rtl/nn_eval_sequencer.sv
// Streams each stored sample into the network, compares its answer with the stored label
// and accumulates match/timeout/per-class statistics over a run.
`timescale 1ns/1ps
module nn_eval_sequencer
  import nn_eval_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned SAMPLE_LEN  = DefSampleLen,
  parameter int unsigned NUM_CLASSES = DefNumClasses,
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned TIMEOUT     = DefTimeout,
  localparam int unsigned CLASS_WIDTH = $clog2(NUM_CLASSES),
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_SAMPLES * (SAMPLE_LEN + 1)),
  localparam int unsigned CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  nn_eval_sequencer_if.master    nn,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   match_count,
  output logic [CNT_WIDTH-1:0]   sample_count,
  output logic [CNT_WIDTH-1:0]   timeout_count,
  input  logic [CLASS_WIDTH-1:0] class_sel,
  output logic [CNT_WIDTH-1:0]   class_hits,
  output logic [CNT_WIDTH-1:0]   class_total
);
  localparam int unsigned WaitWidth = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CntSat = CNT_WIDTH'(NUM_SAMPLES);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, pix_q;
  logic [CNT_WIDTH-1:0]   idx_q, match_cnt_q, sample_cnt_q, to_cnt_q;
  logic [WaitWidth-1:0]   wait_q;
  logic [DATA_WIDTH-1:0]  label_q;
  logic [CLASS_WIDTH-1:0] result_q;
  logic                   lbl_phase_q, timed_out_q, net_valid_q;
  logic                   last_pix, wait_expired, label_ok, hit, score_en;

  assign last_pix     = pix_q == ADDR_WIDTH'(SAMPLE_LEN - 1);
  assign wait_expired = wait_q == WaitWidth'(TIMEOUT - 1);
  assign label_ok     = label_q < DATA_WIDTH'(NUM_CLASSES);
  assign hit          = !timed_out_q && label_ok && (result_q == label_q[CLASS_WIDTH-1:0]);
  assign score_en     = (state_q == StScore) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    nn.mem_rd_en = 1'b0;
    nn.mem_addr  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        busy         = 1'b1;
        nn.mem_rd_en = 1'b1;
        nn.mem_addr  = base_q + pix_q;
        if (last_pix) state_d = StLabel;
      end
      // Phase 0 issues the label read, phase 1 captures the returned word.
      StLabel: begin
        busy = 1'b1;
        if (!lbl_phase_q) begin
          nn.mem_rd_en = 1'b1;
          nn.mem_addr  = base_q + ADDR_WIDTH'(SAMPLE_LEN);
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (nn.net_out_valid || wait_expired) state_d = StScore;
      end
      StScore: begin
        busy    = 1'b1;
        state_d = (idx_q < CNT_WIDTH'(NUM_SAMPLES - 1)) ? StFetch : StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      pix_q        <= '0;
      idx_q        <= '0;
      match_cnt_q  <= '0;
      sample_cnt_q <= '0;
      to_cnt_q     <= '0;
      wait_q       <= '0;
      label_q      <= '0;
      result_q     <= '0;
      lbl_phase_q  <= 1'b0;
      timed_out_q  <= 1'b0;
      net_valid_q  <= 1'b0;
    end else begin
      // Read data returns one cycle after each pixel read, so the stream lags FETCH by one.
      net_valid_q <= (state_q == StFetch) && !abort;
      case (state_q)
        StIdle: begin
          if (start) begin
            base_q       <= '0;
            pix_q        <= '0;
            idx_q        <= '0;
            lbl_phase_q  <= 1'b0;
            match_cnt_q  <= '0;
            sample_cnt_q <= '0;
            to_cnt_q     <= '0;
          end
        end
        StFetch: pix_q <= last_pix ? '0 : pix_q + 1'b1;
        StLabel: begin
          lbl_phase_q <= ~lbl_phase_q;
          wait_q      <= '0;
          if (lbl_phase_q) label_q <= nn.mem_rd_data;
        end
        StWait: begin
          wait_q <= wait_q + 1'b1;
          if (nn.net_out_valid) begin
            result_q    <= nn.net_out_data;
            timed_out_q <= 1'b0;
          end else if (wait_expired) begin
            timed_out_q <= 1'b1;
          end
        end
        StScore: begin
          if (!abort) begin
            if (sample_cnt_q != CntSat) sample_cnt_q <= sample_cnt_q + 1'b1;
            if (timed_out_q && (to_cnt_q != CntSat)) to_cnt_q <= to_cnt_q + 1'b1;
            if (hit && (match_cnt_q != CntSat)) match_cnt_q <= match_cnt_q + 1'b1;
            if (idx_q < CNT_WIDTH'(NUM_SAMPLES - 1)) begin
              idx_q  <= idx_q + 1'b1;
              base_q <= base_q + ADDR_WIDTH'(SAMPLE_LEN + 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign nn.net_valid  = net_valid_q;
  assign nn.net_data   = net_valid_q ? nn.mem_rd_data : '0;
  assign match_count   = match_cnt_q;
  assign sample_count  = sample_cnt_q;
  assign timeout_count = to_cnt_q;

  nn_eval_class_counters #(
    .NUM_CLASSES (NUM_CLASSES),
    .CLASS_WIDTH (CLASS_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH),
    .SAT_VALUE   (NUM_SAMPLES)
  ) u_class_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       ((state_q == StIdle) && start),
    .update      (score_en && label_ok),
    .label       (label_q[CLASS_WIDTH-1:0]),
    .hit         (hit),
    .class_sel   (class_sel),
    .class_hits  (class_hits),
    .class_total (class_total)
  );
endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Bench for nn_eval_sequencer: memory and network models, pixel-stream scoreboard, run vectors.
`timescale 1ns/1ps
module tb_nn_eval_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned NC = 10;
  localparam int unsigned NS = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned NW = 2;
  localparam int unsigned NV = 7;

  typedef struct packed {
    logic [NS-1:0][DW-1:0] lab;
    logic [NS-1:0][CW-1:0] res;
    logic [NS-1:0]         rsp;
    int                    dly;
    int                    em;
    int                    es;
    int                    et;
    int                    cls;
    int                    eh;
    int                    etot;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] class_sel = '0;
  logic          busy, done;
  logic [NW-1:0] match_count, sample_count, timeout_count, class_hits, class_total;

  nn_eval_sequencer_if #(.DATA_WIDTH(DW), .CLASS_WIDTH(CW), .ADDR_WIDTH(AW)) nn ();

  nn_eval_sequencer #(
    .DATA_WIDTH  (DW),
    .SAMPLE_LEN  (SL),
    .NUM_CLASSES (NC),
    .NUM_SAMPLES (NS),
    .TIMEOUT     (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .nn            (nn),
    .busy          (busy),
    .done          (done),
    .match_count   (match_count),
    .sample_count  (sample_count),
    .timeout_count (timeout_count),
    .class_sel     (class_sel),
    .class_hits    (class_hits),
    .class_total   (class_total)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read sample memory.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] rd_data;
  always @(posedge clk) if (nn.mem_rd_en) rd_data <= mem[nn.mem_addr];
  assign nn.mem_rd_data = rd_data;

  // Network model: answers a fixed number of cycles after the last pixel of each sample.
  bit            rsp_en [NS];
  logic [CW-1:0] rsp_val [NS];
  int            rsp_dly;
  int            beat, s_idx, cur_s, dly_cnt;
  bit            armed;
  logic          mdl_vld;
  logic [CW-1:0] mdl_data;
  logic          stray = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= 0; s_idx <= 0; cur_s <= 0; dly_cnt <= 0; armed <= 1'b0;
      mdl_vld <= 1'b0; mdl_data <= '0;
    end else begin
      mdl_vld <= 1'b0;
      if (start) begin
        beat <= 0; s_idx <= 0; armed <= 1'b0;
      end else begin
        if (nn.net_valid) begin
          if (beat == int'(SL) - 1) begin
            beat <= 0; armed <= 1'b1; dly_cnt <= rsp_dly; cur_s <= s_idx; s_idx <= s_idx + 1;
          end else begin
            beat <= beat + 1;
          end
        end
        if (armed) begin
          if (dly_cnt == 0) begin
            armed <= 1'b0;
            mdl_vld <= rsp_en[cur_s];
            mdl_data <= rsp_val[cur_s];
          end else begin
            dly_cnt <= dly_cnt - 1;
          end
        end
      end
    end
  end
  assign nn.net_out_valid = mdl_vld | stray;
  assign nn.net_out_data  = mdl_data;

  // Scoreboard of expected pixel beats, filled when a sample image is loaded.
  logic [DW-1:0] pix_q [$];
  int            run = 0;
  int            done_cnt = 0;
  logic          done_prev = 1'b0;
  bit            skip_run = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (nn.net_valid) begin
        run++;
        check("pixel_expected", 32'(pix_q.size() != 0), 1);
        if (pix_q.size() != 0) check("net_data", nn.net_data, pix_q.pop_front());
      end else begin
        if (run != 0 && !skip_run) check("net_valid_run", run, SL);
        run = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", done_prev, 0);
      end
      done_prev = done;
    end else begin
      run = 0;
      done_prev = 1'b0;
    end
  end

  function automatic logic [DW-1:0] pix(input int r, input int s, input int p);
    return DW'(32'h11 + p + (s << 8) + (r << 12));
  endfunction

  function automatic vec_t mk(input int l0, input int l1, input int l2, input int r0,
                              input int r1, input int r2, input logic [2:0] rsp,
                              input int dly, input int em, input int es, input int et,
                              input int cls, input int eh, input int etot);
    vec_t v;
    v.lab[0] = DW'(l0); v.lab[1] = DW'(l1); v.lab[2] = DW'(l2);
    v.res[0] = CW'(r0); v.res[1] = CW'(r1); v.res[2] = CW'(r2);
    v.rsp = rsp; v.dly = dly; v.em = em; v.es = es; v.et = et;
    v.cls = cls; v.eh = eh; v.etot = etot;
    return v;
  endfunction

  vec_t vecs [NV];

  task automatic load_rec(input int r);
    vec_t v = vecs[r];
    for (int s = 0; s < int'(NS); s++) begin
      for (int p = 0; p < int'(SL); p++) begin
        mem[s * (SL + 1) + p] = pix(r, s, p);
        pix_q.push_back(pix(r, s, p));
      end
      mem[s * (SL + 1) + SL] = v.lab[s];
      rsp_en[s]  = v.rsp[s];
      rsp_val[s] = v.res[s];
    end
    rsp_dly = v.dly;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  task automatic wait_fetch1(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sample_count == 1 && nn.net_valid) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  task automatic run_vec(input int r);
    vec_t v = vecs[r];
    int   d0 = done_cnt;
    load_rec(r);
    pulse_start();
    check($sformatf("v%0d_busy_start", r), busy, 1);
    check($sformatf("v%0d_cleared", r), sample_count, 0);
    wait_done($sformatf("v%0d_done_seen", r));
    @(posedge clk); #1;
    check($sformatf("v%0d_busy_end", r), busy, 0);
    check($sformatf("v%0d_match", r), match_count, v.em);
    check($sformatf("v%0d_samples", r), sample_count, v.es);
    check($sformatf("v%0d_timeouts", r), timeout_count, v.et);
    class_sel = CW'(v.cls);
    #1;
    check($sformatf("v%0d_class_hits", r), class_hits, v.eh);
    check($sformatf("v%0d_class_total", r), class_total, v.etot);
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("v%0d_done_pulses", r), done_cnt - d0, 1);
    check($sformatf("v%0d_pixels_left", r), pix_q.size(), 0);
    check($sformatf("v%0d_match_hold", r), match_count, v.em);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int s = 0; s < int'(NS); s++) begin
      rsp_en[s] = 1'b0;
      rsp_val[s] = '0;
    end
    rsp_dly = 0;
    //                  labels      results    rsp    dly  m  s  t  cls h tot
    vecs[0] = mk(3, 7, 1,   3, 7, 1,   3'b111, 4,   3, 3, 0, 7, 1, 1);
    vecs[1] = mk(3, 7, 1,   3, 7, 1,   3'b101, 4,   2, 3, 1, 7, 0, 1);
    vecs[2] = mk(3, 12, 1,  3, 2, 1,   3'b111, 0,   2, 3, 0, 2, 0, 0);
    vecs[3] = mk(5, 5, 5,   5, 4, 5,   3'b111, 7,   2, 3, 0, 5, 2, 3);
    vecs[4] = mk(9, 0, 9,   9, 0, 8,   3'b111, 15,  2, 3, 0, 9, 1, 2);
    vecs[5] = mk(10, 10, 0, 10, 10, 0, 3'b111, 2,   1, 3, 0, 0, 1, 1);
    vecs[6] = mk(2, 4, 6,   2, 4, 6,   3'b111, 16,  0, 3, 3, 4, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_net_valid", nn.net_valid, 0);
    check("rst_net_data", nn.net_data, 0);
    check("rst_mem_rd_en", nn.mem_rd_en, 0);
    check("rst_mem_addr", nn.mem_addr, 0);
    check("rst_match", match_count, 0);
    check("rst_samples", sample_count, 0);
    check("rst_timeouts", timeout_count, 0);
    rst_n = 1'b1;

    for (int r = 0; r < int'(NV); r++) run_vec(r);

    // Abort while the second sample is streaming.
    d0 = done_cnt;
    load_rec(0);
    pulse_start();
    wait_fetch1("abort_reach_fetch1");
    skip_run = 1'b1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_net_valid", nn.net_valid, 0);
    check("abort_mem_rd_en", nn.mem_rd_en, 0);
    check("abort_samples", sample_count, 1);
    check("abort_match", match_count, 1);
    pix_q.delete();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_samples_hold", sample_count, 1);
    check("abort_still_idle", busy, 0);
    skip_run = 1'b0;
    load_rec(0);
    pulse_start();
    check("restart_samples_clear", sample_count, 0);
    check("restart_match_clear", match_count, 0);
    check("restart_busy", busy, 1);
    wait_done("restart_done_seen");
    @(posedge clk); #1;
    check("restart_match", match_count, 3);
    check("restart_samples", sample_count, 3);

    // Reset while waiting on a silent network during the second sample.
    d0 = done_cnt;
    load_rec(1);
    pulse_start();
    wait_fetch1("rst_reach_fetch1");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!nn.net_valid) break;
    end
    repeat (3) @(negedge clk);
    check("rst_pre_samples", sample_count, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_net_valid", nn.net_valid, 0);
    check("midrst_net_data", nn.net_data, 0);
    check("midrst_mem_rd_en", nn.mem_rd_en, 0);
    check("midrst_mem_addr", nn.mem_addr, 0);
    check("midrst_match", match_count, 0);
    check("midrst_samples", sample_count, 0);
    check("midrst_timeouts", timeout_count, 0);
    pix_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 stray = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stray_match", match_count, 0);
    check("stray_samples", sample_count, 0);
    check("stray_timeouts", timeout_count, 0);
    check("stray_busy", busy, 0);
    check("midrst_no_done", done_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
